pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline control for the in-order core. It resolves branches and jumps in EX and computes the jump target.
//  It generates per-stage hold and flush vectors for taken jumps, load-use hazards, data-memory stalls and multi-cycle
//  (mul/div) EX ops, using a wait FSM with a watchdog timeout and a programmable-length fetch mask after a redirect.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_if.sv | 47 ++++
 rtl/branch_cmp.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: jump/branch flag
// encodings, pipeline stage indices and the multi-cycle wait FSM states.
package pipe_ctrl_pkg;

    localparam int JF_ENC_W = 4;

    localparam logic [JF_ENC_W-1:0] JF_NONE = 4'd0;
    localparam logic [JF_ENC_W-1:0] JF_BEQ  = 4'd1;
    localparam logic [JF_ENC_W-1:0] JF_BNE  = 4'd2;
    localparam logic [JF_ENC_W-1:0] JF_BLT  = 4'd3;
    localparam logic [JF_ENC_W-1:0] JF_BGE  = 4'd4;
    localparam logic [JF_ENC_W-1:0] JF_BLTU = 4'd5;
    localparam logic [JF_ENC_W-1:0] JF_BGEU = 4'd6;
    localparam logic [JF_ENC_W-1:0] JF_JMP  = 4'd7;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MC_WAIT  = 2'd1,
        ST_MC_ABORT = 2'd2
    } mc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// Handshake: there is no valid/ready pair; every *_i signal is sampled as a
// level each cycle, and every *_o signal is a per-cycle command that the
// datapath must obey in that same cycle (hold/flush/redirect).
// The controller drives the slave side; the datapath (or a bench) the master.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_STG = 5,
    parameter int JF_W    = 4
);
    logic [ADDR_W-1:0]  jmp_base_i;
    logic [ADDR_W-1:0]  jmp_off_i;
    logic [XLEN-1:0]    rs1_data_i;
    logic [XLEN-1:0]    rs2_data_i;
    logic [JF_W-1:0]    jmp_flag_i;
    logic               load_use_i;
    logic               mc_req_i;
    logic               mc_done_i;
    logic               mem_stall_i;

    logic               jmp_en_o;
    logic [ADDR_W-1:0]  jmp_to_o;
    logic               instr_mask_o;
    logic [NUM_STG-1:0] hold_o;
    logic [NUM_STG-1:0] flush_o;
    logic               busy_o;
    logic               mc_timeout_o;
    mc_state_e          dbg_state;

    modport master (
        output jmp_base_i, jmp_off_i, rs1_data_i, rs2_data_i, jmp_flag_i,
               load_use_i, mc_req_i, mc_done_i, mem_stall_i,
        input  jmp_en_o, jmp_to_o, instr_mask_o, hold_o, flush_o, busy_o,
               mc_timeout_o, dbg_state
    );

    modport slave (
        input  jmp_base_i, jmp_off_i, rs1_data_i, rs2_data_i, jmp_flag_i,
               load_use_i, mc_req_i, mc_done_i, mem_stall_i,
        output jmp_en_o, jmp_to_o, instr_mask_o, hold_o, flush_o, busy_o,
               mc_timeout_o, dbg_state
    );

endinterface

// File: rtl/branch_cmp.sv
// Branch condition evaluation: full-width equal / signed-less / unsigned-less
// compares, decoded against the jump flag into a single taken bit.
module branch_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int JF_W = 4
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [JF_W-1:0] flag,
    output logic            taken
);

    logic eq;
    logic slt;
    logic sltu;

    assign eq   = (rs1 == rs2);
    assign slt  = ($signed(rs1) < $signed(rs2));
    assign sltu = (rs1 < rs2);

    // Flag decode; unknown encodings behave like NONE.
    always_comb begin
        taken = 1'b0;
        case (flag)
            JF_W'(JF_BEQ):  taken = eq;
            JF_W'(JF_BNE):  taken = ~eq;
            JF_W'(JF_BLT):  taken = slt;
            JF_W'(JF_BGE):  taken = ~slt;
            JF_W'(JF_BLTU): taken = sltu;
            JF_W'(JF_BGEU): taken = ~sltu;
            JF_W'(JF_JMP):  taken = 1'b1;
            default:        taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the in-order core: resolves branches in EX, computes
// the redirect target, and produces per-stage hold/flush vectors for memory
// stalls, multi-cycle EX ops (with watchdog) and load-use hazards.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int NUM_STG    = 5,
    parameter int FLUSH_LEN  = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int JF_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int WD_W = $clog2(MC_TIMEOUT + 1);

    mc_state_e          state_q;
    mc_state_e          state_d;
    logic [WD_W-1:0]    wd_q;
    logic [WD_W-1:0]    wd_d;
    logic [3:0]         flush_cnt_q;

    logic               taken;
    logic [ADDR_W-1:0]  sum;
    logic [NUM_STG-1:0] hold;
    logic [NUM_STG-1:0] flush;
    logic               jmp_en;
    logic               mc_to;

    branch_cmp #(
        .XLEN (XLEN),
        .JF_W (JF_W)
    ) u_cmp (
        .rs1   (bus.rs1_data_i),
        .rs2   (bus.rs2_data_i),
        .flag  (bus.jmp_flag_i),
        .taken (taken)
    );

    // Target is always computed, independent of reset, with bit 0 cleared.
    assign sum = bus.jmp_base_i + bus.jmp_off_i;
    assign bus.jmp_to_o = {sum[ADDR_W-1:1], 1'b0};

    // Wait FSM next state; a memory stall freezes both state and watchdog.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        if (!bus.mem_stall_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mc_req_i) begin
                        state_d = ST_MC_WAIT;
                        wd_d    = WD_W'(1);
                    end
                end
                ST_MC_WAIT: begin
                    // done is checked first so it wins over the timeout
                    if (bus.mc_done_i) begin
                        state_d = ST_IDLE;
                    end else if (wd_q == WD_W'(MC_TIMEOUT)) begin
                        state_d = ST_MC_ABORT;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                ST_MC_ABORT: state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Hold/flush priority: mem stall, multi-cycle wait, abort, load-use;
    // jump flushes of IF/ID are layered on top when the redirect fires.
    always_comb begin
        hold   = '0;
        flush  = '0;
        jmp_en = 1'b0;
        mc_to  = 1'b0;
        if (!rst) begin
            if (bus.mem_stall_i) begin
                hold[STG_IF]  = 1'b1;
                hold[STG_ID]  = 1'b1;
                hold[STG_EX]  = 1'b1;
                hold[STG_MEM] = 1'b1;
                flush[STG_WB] = 1'b1;
            end else if ((state_q == ST_MC_WAIT && !bus.mc_done_i) ||
                         (state_q == ST_IDLE && bus.mc_req_i)) begin
                hold[STG_IF]   = 1'b1;
                hold[STG_ID]   = 1'b1;
                hold[STG_EX]   = 1'b1;
                flush[STG_MEM] = 1'b1;
            end else if (state_q == ST_MC_ABORT) begin
                flush[STG_EX] = 1'b1;
                mc_to         = 1'b1;
            end else if (bus.load_use_i && !taken) begin
                // a taken jump makes the ID instruction wrong-path anyway
                hold[STG_IF]  = 1'b1;
                hold[STG_ID]  = 1'b1;
                flush[STG_EX] = 1'b1;
            end
            jmp_en = taken & ~hold[STG_EX];
            if (jmp_en) begin
                flush[STG_IF] = 1'b1;
                flush[STG_ID] = 1'b1;
            end
        end
    end

    // Wrong-path fetch counter: reloads on every redirect, counts down only
    // on cycles in which IF actually advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
        end else if (jmp_en) begin
            flush_cnt_q <= 4'(FLUSH_LEN);
        end else if (!hold[STG_IF] && flush_cnt_q != 4'd0) begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
        end
    end

    assign bus.jmp_en_o     = jmp_en;
    assign bus.hold_o       = hold;
    assign bus.flush_o      = flush;
    assign bus.instr_mask_o = (flush_cnt_q != 4'd0);
    assign bus.busy_o       = (state_q == ST_MC_WAIT);
    assign bus.mc_timeout_o = mc_to;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: branch resolution, load-use, multi-cycle
// wait with watchdog, memory stalls, redirect mask timing and async reset.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if #(
        .XLEN (32), .ADDR_W (32), .NUM_STG (5), .JF_W (4)
    ) bus ();

    pipe_hazard_ctrl #(
        .XLEN (32), .ADDR_W (32), .NUM_STG (5),
        .FLUSH_LEN (2), .MC_TIMEOUT (8), .JF_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.jmp_base_i  = 32'h0000_1000;
        bus.jmp_off_i   = 32'h0000_0010;
        bus.rs1_data_i  = '0;
        bus.rs2_data_i  = '0;
        bus.jmp_flag_i  = JF_NONE;
        bus.load_use_i  = 1'b0;
        bus.mc_req_i    = 1'b0;
        bus.mc_done_i   = 1'b0;
        bus.mem_stall_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.jmp_off_i   = 32'h0000_0011;
        bus.mem_stall_i = 1'b1;
        bus.load_use_i  = 1'b1;
        bus.mc_req_i    = 1'b1;
        bus.jmp_flag_i  = JF_JMP;
        #3;
        checks++; if (bus.hold_o !== 5'b0) begin failures++; $display("FAIL rst_hold got=%b exp=00000", bus.hold_o); end
        checks++; if (bus.flush_o !== 5'b0) begin failures++; $display("FAIL rst_flush got=%b exp=00000", bus.flush_o); end
        checks++; if (bus.jmp_en_o !== 1'b0) begin failures++; $display("FAIL rst_jmp_en got=%b exp=0", bus.jmp_en_o); end
        checks++; if (bus.instr_mask_o !== 1'b0) begin failures++; $display("FAIL rst_mask got=%b exp=0", bus.instr_mask_o); end
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.mc_timeout_o !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", bus.mc_timeout_o); end
        checks++; if (bus.jmp_to_o !== 32'h0000_1010) begin failures++; $display("FAIL rst_jmp_to got=%h exp=00001010", bus.jmp_to_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++; if (bus.hold_o !== 5'b0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL post_rst_idle hold=%b busy=%b exp=00000/0", bus.hold_o, bus.busy_o); end
        tick();
    endtask

    task automatic test_blt();
        bus.jmp_flag_i = JF_BLT;
        bus.rs1_data_i = 32'hFFFF_FFFF;
        bus.rs2_data_i = 32'h0000_0001;
        @(negedge clk);
        checks++; if (bus.jmp_en_o !== 1'b1) begin failures++; $display("FAIL blt_en got=%b exp=1", bus.jmp_en_o); end
        checks++; if (bus.jmp_to_o !== 32'h0000_1010) begin failures++; $display("FAIL blt_to got=%h exp=00001010", bus.jmp_to_o); end
        checks++; if (bus.flush_o !== 5'b00011) begin failures++; $display("FAIL blt_flush got=%b exp=00011", bus.flush_o); end
        checks++; if (bus.hold_o !== 5'b0) begin failures++; $display("FAIL blt_hold got=%b exp=00000", bus.hold_o); end
        tick();
        drive_idle();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++; if (bus.instr_mask_o !== (c <= 2)) begin failures++; $display("FAIL blt_mask_c%0d got=%b exp=%b", c, bus.instr_mask_o, (c <= 2)); end
            tick();
        end
    endtask

    task automatic test_unsigned();
        bus.jmp_flag_i = JF_BGEU;
        bus.rs1_data_i = 32'hFFFF_FFFF;
        bus.rs2_data_i = 32'h0000_0001;
        @(negedge clk);
        checks++; if (bus.jmp_en_o !== 1'b1) begin failures++; $display("FAIL bgeu_en got=%b exp=1", bus.jmp_en_o); end
        tick();
        bus.jmp_flag_i = JF_NONE;
        tick();
        tick();
        bus.jmp_flag_i = JF_BLTU;
        @(negedge clk);
        checks++; if (bus.jmp_en_o !== 1'b0) begin failures++; $display("FAIL bltu_en got=%b exp=0", bus.jmp_en_o); end
        checks++; if (bus.flush_o !== 5'b0) begin failures++; $display("FAIL bltu_flush got=%b exp=00000", bus.flush_o); end
        tick();
        bus.jmp_flag_i = JF_BGE;
        @(negedge clk);
        checks++; if (bus.instr_mask_o !== 1'b0) begin failures++; $display("FAIL bltu_mask got=%b exp=0", bus.instr_mask_o); end
        checks++; if (bus.jmp_en_o !== 1'b0) begin failures++; $display("FAIL bge_signed_en got=%b exp=0", bus.jmp_en_o); end
        tick();
        drive_idle();
    endtask

    task automatic test_load_use();
        bus.load_use_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.hold_o !== 5'b00011) begin failures++; $display("FAIL lu_hold got=%b exp=00011", bus.hold_o); end
        checks++; if (bus.flush_o !== 5'b00100) begin failures++; $display("FAIL lu_flush got=%b exp=00100", bus.flush_o); end
        tick();
        bus.load_use_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.hold_o !== 5'b0 || bus.flush_o !== 5'b0) begin failures++; $display("FAIL lu_release hold=%b flush=%b exp=00000/00000", bus.hold_o, bus.flush_o); end
        tick();
        bus.load_use_i = 1'b1;
        bus.jmp_flag_i = JF_BEQ;
        bus.rs1_data_i = 32'h0000_0005;
        bus.rs2_data_i = 32'h0000_0005;
        @(negedge clk);
        checks++; if (bus.jmp_en_o !== 1'b1) begin failures++; $display("FAIL lu_beq_en got=%b exp=1", bus.jmp_en_o); end
        checks++; if (bus.hold_o !== 5'b0) begin failures++; $display("FAIL lu_beq_hold got=%b exp=00000", bus.hold_o); end
        checks++; if (bus.flush_o !== 5'b00011) begin failures++; $display("FAIL lu_beq_flush got=%b exp=00011", bus.flush_o); end
        tick();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_multicycle();
        // jump waiting in EX behind the multi-cycle op until hold releases
        bus.mc_req_i   = 1'b1;
        bus.jmp_flag_i = JF_JMP;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (bus.hold_o !== 5'b00111) begin failures++; $display("FAIL mc_hold_c%0d got=%b exp=00111", c, bus.hold_o); end
            checks++; if (bus.flush_o !== 5'b01000) begin failures++; $display("FAIL mc_flush_c%0d got=%b exp=01000", c, bus.flush_o); end
            checks++; if (bus.busy_o !== (c != 0)) begin failures++; $display("FAIL mc_busy_c%0d got=%b exp=%b", c, bus.busy_o, (c != 0)); end
            checks++; if (bus.jmp_en_o !== 1'b0) begin failures++; $display("FAIL mc_held_jmp_c%0d got=%b exp=0", c, bus.jmp_en_o); end
            tick();
            bus.mc_req_i = 1'b0;
        end
        bus.mc_done_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.hold_o !== 5'b0) begin failures++; $display("FAIL mc_done_hold got=%b exp=00000", bus.hold_o); end
        checks++; if (bus.jmp_en_o !== 1'b1) begin failures++; $display("FAIL mc_done_jmp got=%b exp=1", bus.jmp_en_o); end
        checks++; if (bus.flush_o !== 5'b00011) begin failures++; $display("FAIL mc_done_flush got=%b exp=00011", bus.flush_o); end
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL mc_after_busy got=%b exp=0", bus.busy_o); end
        tick();
        tick();
        // stray done in IDLE
        bus.mc_done_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.hold_o !== 5'b0 || bus.instr_mask_o !== 1'b0) begin failures++; $display("FAIL idle_done hold=%b mask=%b exp=00000/0", bus.hold_o, bus.instr_mask_o); end
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL idle_done_busy got=%b exp=0", bus.busy_o); end
        tick();
    endtask

    task automatic test_timeout();
        bus.mc_req_i = 1'b1;
        tick();
        bus.mc_req_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (bus.busy_o !== 1'b1 || bus.hold_o !== 5'b00111 || bus.mc_timeout_o !== 1'b0) begin failures++; $display("FAIL to_wait_c%0d busy=%b hold=%b to=%b exp=1/00111/0", c, bus.busy_o, bus.hold_o, bus.mc_timeout_o); end
            tick();
        end
        @(negedge clk);
        checks++; if (bus.mc_timeout_o !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", bus.mc_timeout_o); end
        checks++; if (bus.flush_o !== 5'b00100) begin failures++; $display("FAIL to_flush got=%b exp=00100", bus.flush_o); end
        checks++; if (bus.hold_o !== 5'b0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL to_hold_busy hold=%b busy=%b exp=00000/0", bus.hold_o, bus.busy_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.mc_timeout_o !== 1'b0 || bus.flush_o !== 5'b0) begin failures++; $display("FAIL to_after to=%b flush=%b exp=0/00000", bus.mc_timeout_o, bus.flush_o); end
        tick();
        // done arriving exactly at the watchdog limit wins
        bus.mc_req_i = 1'b1;
        tick();
        bus.mc_req_i = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        bus.mc_done_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.hold_o !== 5'b0) begin failures++; $display("FAIL dw_hold got=%b exp=00000", bus.hold_o); end
        tick();
        bus.mc_done_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.mc_timeout_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.flush_o !== 5'b0) begin failures++; $display("FAIL dw_after to=%b busy=%b flush=%b exp=0/0/00000", bus.mc_timeout_o, bus.busy_o, bus.flush_o); end
        tick();
    endtask

    task automatic test_mem_stall();
        bus.jmp_flag_i  = JF_BEQ;
        bus.rs1_data_i  = 32'h0000_0055;
        bus.rs2_data_i  = 32'h0000_0055;
        bus.mem_stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.hold_o !== 5'b01111 || bus.flush_o !== 5'b10000 || bus.jmp_en_o !== 1'b0) begin failures++; $display("FAIL ms_c%0d hold=%b flush=%b en=%b exp=01111/10000/0", c, bus.hold_o, bus.flush_o, bus.jmp_en_o); end
            tick();
        end
        bus.mem_stall_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.jmp_en_o !== 1'b1 || bus.flush_o !== 5'b00011 || bus.hold_o !== 5'b0) begin failures++; $display("FAIL ms_release en=%b flush=%b hold=%b exp=1/00011/00000", bus.jmp_en_o, bus.flush_o, bus.hold_o); end
        tick();
        // mask countdown pauses while IF is held
        drive_idle();
        for (int c = 1; c <= 5; c++) begin
            bus.mem_stall_i = (c <= 2);
            @(negedge clk);
            checks++; if (bus.instr_mask_o !== (c <= 4)) begin failures++; $display("FAIL ms_mask_c%0d got=%b exp=%b", c, bus.instr_mask_o, (c <= 4)); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        bus.jmp_flag_i = JF_JMP;
        @(negedge clk);
        checks++; if (bus.jmp_en_o !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1", bus.jmp_en_o); end
        tick();
        @(negedge clk);
        checks++; if (bus.jmp_en_o !== 1'b1 || bus.instr_mask_o !== 1'b1) begin failures++; $display("FAIL b2b_second en=%b mask=%b exp=1/1", bus.jmp_en_o, bus.instr_mask_o); end
        tick();
        bus.jmp_flag_i = JF_NONE;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (bus.instr_mask_o !== (c <= 3)) begin failures++; $display("FAIL b2b_mask_c%0d got=%b exp=%b", c, bus.instr_mask_o, (c <= 3)); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.jmp_flag_i = JF_JMP;
        tick();
        bus.jmp_flag_i = JF_NONE;
        bus.mc_req_i   = 1'b1;
        tick();
        bus.mc_req_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b1 || bus.instr_mask_o !== 1'b1) begin failures++; $display("FAIL rm_pre busy=%b mask=%b exp=1/1", bus.busy_o, bus.instr_mask_o); end
        #1;
        rst             = 1'b1;
        bus.mem_stall_i = 1'b1;
        bus.load_use_i  = 1'b1;
        bus.jmp_flag_i  = JF_JMP;
        #1;
        checks++; if (bus.busy_o !== 1'b0 || bus.instr_mask_o !== 1'b0) begin failures++; $display("FAIL rm_async busy=%b mask=%b exp=0/0", bus.busy_o, bus.instr_mask_o); end
        checks++; if (bus.hold_o !== 5'b0 || bus.flush_o !== 5'b0 || bus.jmp_en_o !== 1'b0 || bus.mc_timeout_o !== 1'b0) begin failures++; $display("FAIL rm_outs hold=%b flush=%b en=%b to=%b exp=0", bus.hold_o, bus.flush_o, bus.jmp_en_o, bus.mc_timeout_o); end
        tick();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++; if (bus.busy_o !== 1'b0 || bus.instr_mask_o !== 1'b0) begin failures++; $display("FAIL rm_after busy=%b mask=%b exp=0/0", bus.busy_o, bus.instr_mask_o); end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_blt();
        test_unsigned();
        test_load_use();
        test_multicycle();
        test_timeout();
        test_mem_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
